// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU-control pipeline stage: ALUop codes, funct fields,
// ALU control codes, result-source / MDU op encodings and the MDU sequencer states.
package alu_ctrl_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_AND   = 2'b11;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_OR   = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_XOR  = 4'b0011;
  localparam logic [3:0] CTRL_SLL  = 4'b0100;
  localparam logic [3:0] CTRL_SRL  = 4'b0101;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;
  localparam logic [3:0] CTRL_SLT  = 4'b0111;
  localparam logic [3:0] CTRL_SLTU = 4'b1000;
  localparam logic [3:0] CTRL_SRA  = 4'b1001;
  localparam logic [3:0] CTRL_NOR  = 4'b1100;

  localparam logic [1:0] RD_ALU = 2'b00;
  localparam logic [1:0] RD_HI  = 2'b01;
  localparam logic [1:0] RD_LO  = 2'b10;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10
  } mdu_state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUop/funct decoder: ALU control, shift select, result source,
// MDU start/op, illegal-funct flag and HI/LO hazard classification.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [3:0] control,
  output logic       shift,
  output logic [1:0] rd_src,
  output logic       illegal,
  output logic       mdu_start,
  output logic [1:0] mdu_op,
  output logic       hazard
);

  always_comb begin
    control   = CTRL_ADD;
    shift     = 1'b0;
    rd_src    = RD_ALU;
    illegal   = 1'b0;
    mdu_start = 1'b0;
    mdu_op    = MDU_MULT;
    hazard    = 1'b0;
    case (aluop)
      ALUOP_ADD: control = CTRL_ADD;
      ALUOP_SUB: control = CTRL_SUB;
      ALUOP_AND: control = CTRL_AND;
      default: begin
        case (funct)
          F_ADD, F_ADDU: control = CTRL_ADD;
          F_SUB, F_SUBU: control = CTRL_SUB;
          F_AND:         control = CTRL_AND;
          F_OR:          control = CTRL_OR;
          F_XOR:         control = CTRL_XOR;
          F_NOR:         control = CTRL_NOR;
          F_SLT:         control = CTRL_SLT;
          F_SLTU:        control = CTRL_SLTU;
          F_SLL: begin control = CTRL_SLL; shift = 1'b1; end
          F_SRL: begin control = CTRL_SRL; shift = 1'b1; end
          F_SRA: begin control = CTRL_SRA; shift = 1'b1; end
          F_MFHI: begin rd_src = RD_HI; hazard = 1'b1; end
          F_MFLO: begin rd_src = RD_LO; hazard = 1'b1; end
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin
            mdu_start = 1'b1;
            mdu_op    = funct[1:0];
            hazard    = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_control_pipe.sv
// Registered ALU-control stage between ID and EX: output registers, MULT/DIV
// sequencer with busy/done, and the HI/LO interlock on in_ready.
module alu_control_pipe
  import alu_ctrl_pkg::*;
#(
  parameter int CTRL_W     = 4,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        aluop,
  input  logic [5:0]        funct,
  output logic              out_valid,
  output logic [CTRL_W-1:0] out_control,
  output logic              out_shift,
  output logic [1:0]        out_rd_src,
  output logic              out_illegal,
  output logic              out_mdu_start,
  output logic [1:0]        out_mdu_op,
  output logic              busy,
  output logic              mdu_done
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [3:0]       dec_control;
  logic             dec_shift;
  logic [1:0]       dec_rd_src;
  logic             dec_illegal;
  logic             dec_mdu_start;
  logic [1:0]       dec_mdu_op;
  logic             dec_hazard;
  logic             accept;
  mdu_state_t       state;
  logic [CNT_W-1:0] cnt;

  alu_ctrl_decode u_decode (
    .aluop     (aluop),
    .funct     (funct),
    .control   (dec_control),
    .shift     (dec_shift),
    .rd_src    (dec_rd_src),
    .illegal   (dec_illegal),
    .mdu_start (dec_mdu_start),
    .mdu_op    (dec_mdu_op),
    .hazard    (dec_hazard)
  );

  // Only HI/LO readers and new MDU ops must wait for a running sequence.
  assign in_ready = !(busy && in_valid && dec_hazard);
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_control   <= '0;
      out_shift     <= 1'b0;
      out_rd_src    <= RD_ALU;
      out_illegal   <= 1'b0;
      out_mdu_start <= 1'b0;
      out_mdu_op    <= MDU_MULT;
    end else if (accept) begin
      out_valid     <= 1'b1;
      out_control   <= CTRL_W'(dec_control);
      out_shift     <= dec_shift;
      out_rd_src    <= dec_rd_src;
      out_illegal   <= dec_illegal;
      out_mdu_start <= dec_mdu_start;
      out_mdu_op    <= dec_mdu_op;
    end else begin
      out_valid     <= 1'b0;
      out_illegal   <= 1'b0;
      out_mdu_start <= 1'b0;
    end
  end

  // Counter is loaded with N-1 so busy covers exactly N cycles before done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      mdu_done <= 1'b0;
    end else begin
      mdu_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept && dec_mdu_start) begin
            busy <= 1'b1;
            if (dec_mdu_op[1]) begin
              state <= ST_DIV;
              cnt   <= CNT_W'(DIV_CYCLES - 1);
            end else begin
              state <= ST_MUL;
              cnt   <= CNT_W'(MUL_CYCLES - 1);
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            mdu_done <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_control_pipe.sv
// Directed self-checking bench for alu_control_pipe: default instance (MUL 4 / DIV 32)
// plus a MUL_CYCLES=1 instance for back-to-back multiply spacing.
module tb_alu_control_pipe;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_valid1;
  logic [1:0] aluop;
  logic [5:0] funct;

  logic       in_ready, out_valid, out_shift, out_illegal, out_mdu_start, busy, mdu_done;
  logic [3:0] out_control;
  logic [1:0] out_rd_src, out_mdu_op;

  logic       m1_in_ready, m1_out_valid, m1_out_shift, m1_out_illegal, m1_out_mdu_start;
  logic       m1_busy, m1_mdu_done;
  logic [3:0] m1_out_control;
  logic [1:0] m1_out_rd_src, m1_out_mdu_op;

  int total = 0;
  int bad   = 0;

  alu_control_pipe #(.CTRL_W(4), .MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .aluop(aluop), .funct(funct), .out_valid(out_valid), .out_control(out_control),
    .out_shift(out_shift), .out_rd_src(out_rd_src), .out_illegal(out_illegal),
    .out_mdu_start(out_mdu_start), .out_mdu_op(out_mdu_op), .busy(busy), .mdu_done(mdu_done)
  );

  alu_control_pipe #(.CTRL_W(4), .MUL_CYCLES(1), .DIV_CYCLES(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid1), .in_ready(m1_in_ready),
    .aluop(aluop), .funct(funct), .out_valid(m1_out_valid), .out_control(m1_out_control),
    .out_shift(m1_out_shift), .out_rd_src(m1_out_rd_src), .out_illegal(m1_out_illegal),
    .out_mdu_start(m1_out_mdu_start), .out_mdu_op(m1_out_mdu_op), .busy(m1_busy),
    .mdu_done(m1_mdu_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] aop, input logic [5:0] f,
                               input logic fl);
    in_valid = v;
    aluop    = aop;
    funct    = f;
    flush    = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One decode per cycle; outputs of the vector appear after the next edge.
  task automatic sweepOne(input logic [1:0] aop, input logic [5:0] f, input logic [3:0] ctrl,
                          input logic sh, input logic [1:0] rd, input logic ill);
    applyStimulus(1'b1, aop, f, 1'b0);
    tick();
    checkOutput($sformatf("sweep_valid_%b_%b", aop, f), out_valid, 1);
    checkOutput($sformatf("sweep_ctrl_%b_%b", aop, f), out_control, ctrl);
    checkOutput($sformatf("sweep_shift_%b_%b", aop, f), out_shift, sh);
    checkOutput($sformatf("sweep_rd_%b_%b", aop, f), out_rd_src, rd);
    checkOutput($sformatf("sweep_illegal_%b_%b", aop, f), out_illegal, ill);
  endtask

  initial begin
    int busyCycles;
    int doneCount;
    logic doneAtFall;

    rst_n = 1'b0;
    in_valid1 = 1'b0;
    applyStimulus(1'b0, 2'b00, 6'b000000, 1'b0);
    #11;
    checkOutput("reset_valid", out_valid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", mdu_done, 0);
    checkOutput("reset_ctrl", out_control, 0);
    checkOutput("reset_ready", in_ready, 1);
    rst_n = 1'b1;
    tick();

    $display("[TB] decode sweep");
    sweepOne(2'b00, 6'b000000, 4'b0010, 0, 2'b00, 0);
    sweepOne(2'b01, 6'b000000, 4'b0110, 0, 2'b00, 0);
    sweepOne(2'b11, 6'b000000, 4'b0000, 0, 2'b00, 0);
    sweepOne(2'b10, 6'b100000, 4'b0010, 0, 2'b00, 0);
    sweepOne(2'b10, 6'b100001, 4'b0010, 0, 2'b00, 0);
    sweepOne(2'b10, 6'b100010, 4'b0110, 0, 2'b00, 0);
    sweepOne(2'b10, 6'b100011, 4'b0110, 0, 2'b00, 0);
    sweepOne(2'b10, 6'b100100, 4'b0000, 0, 2'b00, 0);
    sweepOne(2'b10, 6'b100101, 4'b0001, 0, 2'b00, 0);
    sweepOne(2'b10, 6'b100110, 4'b0011, 0, 2'b00, 0);
    sweepOne(2'b10, 6'b100111, 4'b1100, 0, 2'b00, 0);
    sweepOne(2'b10, 6'b101010, 4'b0111, 0, 2'b00, 0);
    sweepOne(2'b10, 6'b101011, 4'b1000, 0, 2'b00, 0);
    sweepOne(2'b10, 6'b000000, 4'b0100, 1, 2'b00, 0);
    sweepOne(2'b10, 6'b000010, 4'b0101, 1, 2'b00, 0);
    sweepOne(2'b10, 6'b000011, 4'b1001, 1, 2'b00, 0);
    sweepOne(2'b10, 6'b010000, 4'b0010, 0, 2'b01, 0);
    sweepOne(2'b10, 6'b010010, 4'b0010, 0, 2'b10, 0);
    sweepOne(2'b10, 6'b000001, 4'b0010, 0, 2'b00, 1);
    sweepOne(2'b10, 6'b111111, 4'b0010, 0, 2'b00, 1);
    applyStimulus(1'b0, 2'b01, 6'b000000, 1'b0);
    tick();
    checkOutput("idle_valid", out_valid, 0);
    checkOutput("idle_illegal", out_illegal, 0);
    checkOutput("idle_ctrl_hold", out_control, 4'b0010);
    checkOutput("idle_busy", busy, 0);

    $display("[TB] mult then mflo");
    applyStimulus(1'b1, 2'b10, 6'b011000, 1'b0);
    tick();
    checkOutput("mult_valid", out_valid, 1);
    checkOutput("mult_start", out_mdu_start, 1);
    checkOutput("mult_op", out_mdu_op, 2'b00);
    checkOutput("mult_busy", busy, 1);
    applyStimulus(1'b1, 2'b10, 6'b010010, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("mflo_stall_ready_%0d", i), in_ready, 0);
      tick();
      checkOutput($sformatf("mflo_stall_valid_%0d", i), out_valid, 0);
      checkOutput($sformatf("mflo_stall_done_%0d", i), mdu_done, (i == 3) ? 1 : 0);
      checkOutput($sformatf("mflo_stall_busy_%0d", i), busy, (i == 3) ? 0 : 1);
    end
    checkOutput("mflo_ready_after", in_ready, 1);
    tick();
    checkOutput("mflo_valid", out_valid, 1);
    checkOutput("mflo_rd_src", out_rd_src, 2'b10);
    checkOutput("mflo_start", out_mdu_start, 0);
    checkOutput("mflo_done_pulse", mdu_done, 0);

    $display("[TB] div with non-hazard traffic");
    applyStimulus(1'b1, 2'b10, 6'b011010, 1'b0);
    tick();
    checkOutput("div_start", out_mdu_start, 1);
    checkOutput("div_op", out_mdu_op, 2'b10);
    checkOutput("div_busy", busy, 1);
    busyCycles = 1;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) applyStimulus(1'b1, 2'b00, 6'b000000, 1'b0);
      else            applyStimulus(1'b1, 2'b10, 6'b100101, 1'b0);
      checkOutput($sformatf("div_flow_ready_%0d", i), in_ready, 1);
      tick();
      checkOutput($sformatf("div_flow_valid_%0d", i), out_valid, 1);
      checkOutput($sformatf("div_flow_ctrl_%0d", i), out_control,
                  (i % 2 == 0) ? 4'b0010 : 4'b0001);
      if (busy) busyCycles++;
    end
    applyStimulus(1'b0, 2'b00, 6'b000000, 1'b0);
    doneAtFall = 1'b0;
    for (int i = 0; i < 40 && busy; i++) begin
      tick();
      if (busy) busyCycles++;
      else doneAtFall = mdu_done;
    end
    checkOutput("div_busy_cycles", busyCycles, 32);
    checkOutput("div_done_at_fall", doneAtFall, 1);

    $display("[TB] flush with mult");
    applyStimulus(1'b1, 2'b10, 6'b011000, 1'b1);
    tick();
    checkOutput("flush_valid", out_valid, 0);
    checkOutput("flush_start", out_mdu_start, 0);
    checkOutput("flush_busy", busy, 0);
    applyStimulus(1'b0, 2'b00, 6'b000000, 1'b0);
    tick();
    checkOutput("flush_busy_after", busy, 0);
    checkOutput("flush_done_after", mdu_done, 0);

    $display("[TB] reset mid-div");
    applyStimulus(1'b1, 2'b10, 6'b011011, 1'b0);
    tick();
    checkOutput("rdiv_busy", busy, 1);
    applyStimulus(1'b0, 2'b00, 6'b000000, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("rdiv_busy_cleared", busy, 0);
    checkOutput("rdiv_op_cleared", out_mdu_op, 0);
    checkOutput("rdiv_ctrl_cleared", out_control, 0);
    checkOutput("rdiv_valid_cleared", out_valid, 0);
    tick();
    rst_n = 1'b1;
    doneCount = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (mdu_done) doneCount++;
    end
    checkOutput("rdiv_no_done", doneCount, 0);
    checkOutput("rdiv_busy_idle", busy, 0);

    $display("[TB] back-to-back mult with MUL_CYCLES=1");
    doneCount = 0;
    in_valid1 = 1'b1;
    applyStimulus(1'b0, 2'b10, 6'b011000, 1'b0);
    tick();
    checkOutput("m1_first_start", m1_out_mdu_start, 1);
    checkOutput("m1_first_busy", m1_busy, 1);
    checkOutput("m1_stall_ready", m1_in_ready, 0);
    tick();
    if (m1_mdu_done) doneCount++;
    checkOutput("m1_done1", m1_mdu_done, 1);
    checkOutput("m1_gap_start", m1_out_mdu_start, 0);
    checkOutput("m1_gap_busy", m1_busy, 0);
    checkOutput("m1_gap_ready", m1_in_ready, 1);
    tick();
    checkOutput("m1_second_start", m1_out_mdu_start, 1);
    checkOutput("m1_second_valid", m1_out_valid, 1);
    checkOutput("m1_second_busy", m1_busy, 1);
    in_valid1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (m1_mdu_done) doneCount++;
    end
    checkOutput("m1_done_pulses", doneCount, 2);
    checkOutput("m1_final_busy", m1_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
